// File: rtl/tribus_arbiter_if.sv
// Request/grant bundle between the tristate drivers and their bus arbiter.
interface tribus_arbiter_if #(
    parameter int N = 4
);
    localparam int OW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          bus_busy;
    logic [OW-1:0] owner;

    // Requesting side: drives requests, sees enables.
    modport master (
        output req,
        input  grant,
        input  bus_busy,
        input  owner
    );

    // Arbiter side.
    modport slave (
        input  req,
        output grant,
        output bus_busy,
        output owner
    );
endinterface

// File: rtl/tribus_arbiter.sv
// Round-robin arbiter for a shared tristate bus. Produces registered one-hot
// driver enables with a dead-time between owners and a hold-time limit that
// applies only while another requester is waiting.
module tribus_arbiter #(
    parameter int N       = 4,
    parameter int DEAD    = 1,
    parameter int MAXHOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    tribus_arbiter_if.slave  bus
);
    localparam int          OW = (N > 1) ? $clog2(N) : 1;
    localparam int          HW = $clog2(MAXHOLD + 1);
    localparam int          DW = $clog2(DEAD + 1);
    localparam int unsigned NU = N;

    localparam logic [HW-1:0] HOLD_SAT  = HW'(MAXHOLD - 1);
    localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD - 1);
    localparam logic [OW-1:0] LAST      = OW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        TURN
    } state_t;

    state_t        state;
    logic [OW-1:0] ptr;
    logic [HW-1:0] hold_cnt;
    logic [DW-1:0] dead_cnt;

    logic          found;
    logic [OW-1:0] win;
    logic [N-1:0]  win_oh;
    logic [31:0]   idx;
    logic          own_req;
    logic          others;

    // Rotating priority search starting at ptr; first set request wins.
    always_comb begin
        found  = 1'b0;
        win    = '0;
        win_oh = '0;
        idx    = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            idx = (32'(ptr) + i) % NU;
            if (!found && bus.req[idx]) begin
                found       = 1'b1;
                win         = OW'(idx);
                win_oh[idx] = 1'b1;
            end
        end
    end

    // Grant is one-hot, so masking with it isolates the owner's request.
    always_comb begin
        own_req = |(bus.req & bus.grant);
        others  = |(bus.req & ~bus.grant);
    end

    // Arbitration FSM with registered enables, owner and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bus.grant    <= '0;
            bus.bus_busy <= 1'b0;
            bus.owner    <= '0;
            ptr          <= '0;
            hold_cnt     <= '0;
            dead_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.grant    <= win_oh;
                        bus.bus_busy <= 1'b1;
                        bus.owner    <= win;
                        hold_cnt     <= '0;
                        state        <= GRANT;
                    end
                end
                GRANT: begin
                    if (!own_req || (hold_cnt == HOLD_SAT && others)) begin
                        bus.grant    <= '0;
                        bus.bus_busy <= 1'b0;
                        bus.owner    <= '0;
                        ptr          <= (bus.owner == LAST) ? '0 : bus.owner + OW'(1);
                        dead_cnt     <= DEAD_INIT;
                        state        <= TURN;
                    end else if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                TURN: begin
                    if (dead_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        dead_cnt <= dead_cnt - DW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tribus_arbiter.sv
// Scoreboard bench for tribus_arbiter (N=4, DEAD=1, MAXHOLD=4) driven by
// directed request vectors with hand-computed grant sequences.
module tb_tribus_arbiter;
    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    typedef struct {
        int         cyc;
        logic [3:0] g;
        string      name;
    } exp_t;

    exp_t sbq[$];

    tribus_arbiter_if #(.N(4)) bus_if ();

    tribus_arbiter #(
        .N      (4),
        .DEAD   (1),
        .MAXHOLD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Monitor: invariant every cycle, scoreboard entry when its cycle arrives.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if ($countones(bus_if.grant) > 1) begin
            errors++;
            $display("FAIL onehot cyc=%0d grant=%b required popcount<=1", cyc, bus_if.grant);
        end
        if (sbq.size() > 0) begin
            if (sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL %s stale entry for cyc=%0d at cyc=%0d", e.name, e.cyc, cyc);
            end else if (sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                checks += 3;
                if (bus_if.grant !== e.g) begin
                    errors++;
                    $display("FAIL %s grant cyc=%0d got=%b exp=%b", e.name, cyc, bus_if.grant, e.g);
                end
                if (bus_if.owner !== idx_of(e.g)) begin
                    errors++;
                    $display("FAIL %s owner cyc=%0d got=%0d exp=%0d", e.name, cyc, bus_if.owner, idx_of(e.g));
                end
                if (bus_if.bus_busy !== (|e.g)) begin
                    errors++;
                    $display("FAIL %s bus_busy cyc=%0d got=%b exp=%b", e.name, cyc, bus_if.bus_busy, |e.g);
                end
            end
        end
    end

    // Apply inputs for one cycle; g is the grant expected after the next edge.
    task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] g, input string nm);
        exp_t e;
        rst        = r;
        bus_if.req = rq;
        e.cyc  = cyc + 1;
        e.g    = g;
        e.name = nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] g;
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        bus_if.req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then single requester; a pulse during TURN is ignored.
        step(1'b1, 4'b0000, 4'b0000, "reset");
        step(1'b0, 4'b0010, 4'b0010, "single_grant");
        step(1'b0, 4'b0010, 4'b0010, "single_hold");
        step(1'b0, 4'b0010, 4'b0010, "single_hold");
        step(1'b0, 4'b0000, 4'b0000, "single_release");
        step(1'b0, 4'b0001, 4'b0000, "turn_ignore");
        step(1'b0, 4'b0000, 4'b0000, "idle_no_memory");

        // All requesting: 4-cycle tenures rotating 0,1,2,3,0 with 2-cycle gaps.
        step(1'b1, 4'b0000, 4'b0000, "reset");
        for (int k = 0; k < 5; k++) begin
            g = 4'b0001 << (k % 4);
            repeat (4) step(1'b0, 4'b1111, g, "rr_grant");
            repeat (2) step(1'b0, 4'b1111, 4'b0000, "rr_gap");
        end

        // Owner 0 releases with 0110 pending: next owner is 1, not 2.
        step(1'b1, 4'b0000, 4'b0000, "reset");
        step(1'b0, 4'b0001, 4'b0001, "rot_grant0");
        step(1'b0, 4'b0110, 4'b0000, "rot_release");
        step(1'b0, 4'b0110, 4'b0000, "rot_gap");
        step(1'b0, 4'b0110, 4'b0010, "rot_grant1");
        step(1'b0, 4'b0000, 4'b0000, "rot_drop");
        step(1'b0, 4'b0000, 4'b0000, "rot_gap");
        step(1'b0, 4'b0000, 4'b0000, "rot_idle");

        // Preemption: competitor appears while hold_cnt=2.
        step(1'b1, 4'b0000, 4'b0000, "reset");
        step(1'b0, 4'b0001, 4'b0001, "pre_h0");
        step(1'b0, 4'b0001, 4'b0001, "pre_h1");
        step(1'b0, 4'b0001, 4'b0001, "pre_h2");
        step(1'b0, 4'b0101, 4'b0001, "pre_h3");
        step(1'b0, 4'b0101, 4'b0000, "pre_release");
        step(1'b0, 4'b0101, 4'b0000, "pre_gap");
        step(1'b0, 4'b0101, 4'b0100, "pre_grant2");
        step(1'b0, 4'b0000, 4'b0000, "pre_drop");
        step(1'b0, 4'b0000, 4'b0000, "pre_gap");

        // No competitor: owner keeps the bus indefinitely.
        step(1'b1, 4'b0000, 4'b0000, "reset");
        repeat (20) step(1'b0, 4'b1000, 4'b1000, "solo_hold");
        step(1'b0, 4'b0000, 4'b0000, "solo_drop");
        step(1'b0, 4'b0000, 4'b0000, "solo_gap");

        // Reset mid-grant, then arbitration restarts from ptr=0; wrap 3->0.
        step(1'b1, 4'b0000, 4'b0000, "reset");
        step(1'b0, 4'b0100, 4'b0100, "mr_grant2");
        step(1'b0, 4'b0100, 4'b0100, "mr_hold");
        step(1'b1, 4'b1100, 4'b0000, "mr_reset");
        step(1'b0, 4'b1100, 4'b0100, "mr_regrant2");
        repeat (3) step(1'b0, 4'b1100, 4'b0100, "mr_hold2");
        step(1'b0, 4'b1100, 4'b0000, "mr_preempt");
        step(1'b0, 4'b1100, 4'b0000, "mr_gap");
        step(1'b0, 4'b1100, 4'b1000, "mr_grant3");
        repeat (3) step(1'b0, 4'b1100, 4'b1000, "mr_hold3");
        step(1'b0, 4'b1100, 4'b0000, "mr_preempt3");
        step(1'b0, 4'b1100, 4'b0000, "mr_gap");
        step(1'b0, 4'b1100, 4'b0100, "mr_wrap_grant2");
        step(1'b0, 4'b0000, 4'b0000, "mr_drop");

        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
